dsp_p_collector: RTL and testbench

// Result-side companion of the DSP48A1 datapath: reads the P/CARRYOUT outputs of a slice

---
 rtl/dsp_p_collector_if.sv | 30 +++
 rtl/dsp_p_collector.sv | 108 ++++++++++
 tb/tb_dsp_p_collector.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/dsp_p_collector_if.sv
// Issue / result stream bundle between a DSP48A1 slice driver and the P-side collector.
// The master drives issues and consumes results; the slave is the collector.
interface dsp_p_collector_if #(
  parameter int PW    = 48,
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          issue_valid;
  logic          issue_ready;
  logic [PW-1:0] p_in;
  logic          cout_in;
  logic          flush;
  logic          m_valid;
  logic          m_ready;
  logic [PW:0]   m_data;
  logic [LW-1:0] level;
  logic          err_drop;
  logic          err_clr;

  modport master (
    output issue_valid, p_in, cout_in, flush, m_ready, err_clr,
    input  issue_ready, m_valid, m_data, level, err_drop
  );

  modport slave (
    input  issue_valid, p_in, cout_in, flush, m_ready, err_clr,
    output issue_ready, m_valid, m_data, level, err_drop
  );
endinterface

// File: rtl/dsp_p_collector.sv
// Tags each issued DSP48A1 operation, captures {CARRYOUT,P} LATENCY edges later into a
// first-word-fall-through FIFO, and grants issue credit only while a slot is guaranteed.
module dsp_p_collector #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 8,
  parameter int PW      = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  dsp_p_collector_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int RW = PW + 1;
  localparam logic [LW:0]   CAP  = (LW + 1)'(DEPTH);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [LATENCY-1:0] tag_q, tag_d;
  logic [LW-1:0]      level_q, level_d;
  logic [LW-1:0]      inflight_q, inflight_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic               err_q, err_d;
  logic [RW-1:0]      wdata_d;
  logic [RW-1:0]      mem_q [DEPTH];

  logic [LW:0] committed;
  logic        issue_ready;
  logic        m_valid;
  logic        accept, drop, push, pop;

  // Credit counts results already queued plus those still travelling through the slice.
  always_comb begin
    committed   = {1'b0, level_q} + {1'b0, inflight_q};
    issue_ready = (committed < CAP);
    m_valid     = (level_q != '0);
    accept      = bus.issue_valid & issue_ready & ~bus.flush;
    drop        = bus.issue_valid & ~issue_ready & ~bus.flush;
    push        = tag_q[LATENCY-1] & ~bus.flush;
    pop         = m_valid & bus.m_ready & ~bus.flush;
    wdata_d     = {bus.cout_in, bus.p_in};
  end

  always_comb begin
    tag_d      = '0;
    inflight_d = '0;
    level_d    = '0;
    wr_ptr_d   = '0;
    rd_ptr_d   = '0;
    if (!bus.flush) begin
      tag_d[0] = accept;
      for (int i = 1; i < LATENCY; i++) begin
        tag_d[i] = tag_q[i-1];
      end
      inflight_d = inflight_q + LW'(accept) - LW'(push);
      level_d    = level_q + LW'(push) - LW'(pop);
      wr_ptr_d   = wr_ptr_q + AW'(push);
      rd_ptr_d   = rd_ptr_q + AW'(pop);
    end
    // A new drop outranks a simultaneous clear so no event is ever lost.
    if (drop) begin
      err_d = 1'b1;
    end else if (bus.err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q      <= '0;
      inflight_q <= '0;
      level_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      level_q    <= level_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      err_q      <= err_d;
    end
  end

  // Result storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata_d;
    end
  end

  // Credit accounting makes a push into a full FIFO impossible.
  always_ff @(posedge clk) begin
    if (rst_n && push && !pop) begin
      assert (level_q != FULL);
    end
  end

  assign bus.issue_ready = issue_ready;
  assign bus.m_valid     = m_valid;
  assign bus.m_data      = m_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.level       = level_q;
  assign bus.err_drop    = err_q;

endmodule

// File: tb/tb_dsp_p_collector.sv
// Directed bench for dsp_p_collector: a transaction queue predicts credit, occupancy,
// result order and data, while the P input follows a per-edge pattern.
module tb_dsp_p_collector;
  localparam int LATENCY = 4;
  localparam int DEPTH   = 8;
  localparam int PW      = 48;

  typedef struct {
    logic [PW:0] d;
    int          pe;
  } ent_t;

  logic clk;
  logic rst_n;
  int   n;
  int   n_cmp;
  int   n_bad;
  bit   auto_p;
  bit   exp_err;
  ent_t q[$];

  dsp_p_collector_if #(.PW(PW), .DEPTH(DEPTH)) bus ();

  dsp_p_collector #(.LATENCY(LATENCY), .DEPTH(DEPTH), .PW(PW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW:0] pat(input int e);
    logic [31:0] ev;
    ev  = 32'(e);
    return {ev[0], 16'hBEEF, ev ^ 32'h5A5A_0000};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s @edge %0d: observed %h expected %h", tag, n, obs, exp);
    end
  endtask

  task automatic step();
    logic [PW:0] tmp;
    @(posedge clk);
    n++;
    #1;
    if (auto_p) begin
      tmp         = pat(n + 1);
      bus.p_in    = tmp[PW-1:0];
      bus.cout_in = tmp[PW];
    end
  endtask

  task automatic tick(input bit iv, input bit mr, input bit clr, input bit fl);
    int          lvl;
    bit          ev, er, acc, pp;
    logic [PW:0] ed, edat;
    int          epe;
    lvl = 0;
    foreach (q[i]) if (q[i].pe <= n) lvl++;
    ev = (lvl != 0);
    er = (q.size() < DEPTH);
    ed = ev ? q[0].d : '0;
    chk("issue_ready", 64'(bus.issue_ready), 64'(er));
    chk("m_valid", 64'(bus.m_valid), 64'(ev));
    chk("m_data", 64'(bus.m_data), 64'(ed));
    chk("level", 64'(bus.level), 64'(lvl));
    chk("err_drop", 64'(bus.err_drop), 64'(exp_err));
    bus.issue_valid = iv;
    bus.m_ready     = mr;
    bus.err_clr     = clr;
    bus.flush       = fl;
    acc  = iv & er & ~fl;
    pp   = ev & mr & ~fl;
    if (!fl && iv && !er) exp_err = 1'b1;
    else if (clr) exp_err = 1'b0;
    epe  = n + 1 + LATENCY;
    edat = pat(epe);
    step();
    if (fl) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back('{edat, epe});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc_n;
    logic [PW:0] tmp;
    n = 0; n_cmp = 0; n_bad = 0; auto_p = 0; exp_err = 0;
    rst_n = 1'b0;
    bus.issue_valid = 1'b0; bus.p_in = '0; bus.cout_in = 1'b0;
    bus.flush = 1'b0; bus.m_ready = 1'b0; bus.err_clr = 1'b0;
    step(); step();
    chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_m_data", 64'(bus.m_data), 64'd0);
    chk("rst_issue_ready", 64'(bus.issue_ready), 64'd1);
    chk("rst_level", 64'(bus.level), 64'd0);
    chk("rst_err_drop", 64'(bus.err_drop), 64'd0);
    rst_n = 1'b1;
    step();

    // single issue with a fixed P value four edges later
    bus.issue_valid = 1'b1;
    step();
    bus.issue_valid = 1'b0;
    step(); step(); step();
    chk("t1_early_valid", 64'(bus.m_valid), 64'd0);
    bus.p_in = 48'h123; bus.cout_in = 1'b1;
    step();
    bus.p_in = '0; bus.cout_in = 1'b0;
    chk("t1_valid", 64'(bus.m_valid), 64'd1);
    chk("t1_data", 64'(bus.m_data), 64'h1_0000_0000_0123);
    chk("t1_level", 64'(bus.level), 64'd1);
    bus.m_ready = 1'b1;
    step();
    bus.m_ready = 1'b0;
    chk("t1_level_after_pop", 64'(bus.level), 64'd0);
    chk("t1_valid_after_pop", 64'(bus.m_valid), 64'd0);
    chk("t1_data_after_pop", 64'(bus.m_data), 64'd0);

    auto_p = 1;
    tmp = pat(n + 1);
    bus.p_in = tmp[PW-1:0]; bus.cout_in = tmp[PW];

    // fill with consumer stalled, overflow attempts, clear, then drain
    repeat (8) tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(1, 0, 1, 0);
    repeat (5) tick(0, 0, 0, 0);
    tick(0, 0, 1, 0);
    repeat (10) tick(0, 1, 0, 0);

    // continuous streaming with consumer always ready
    repeat (20) tick(1, 1, 0, 0);
    repeat (7) tick(0, 1, 0, 0);

    // async reset with one queued and two in flight
    tick(1, 0, 0, 0);
    repeat (4) tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    q.delete();
    exp_err = 0;
    #1;
    chk("ar_m_valid", 64'(bus.m_valid), 64'd0);
    chk("ar_level", 64'(bus.level), 64'd0);
    chk("ar_issue_ready", 64'(bus.issue_ready), 64'd1);
    chk("ar_m_data", 64'(bus.m_data), 64'd0);
    bus.issue_valid = 1'b0;
    step(); step();
    #2;
    rst_n = 1'b1;
    repeat (8) tick(0, 1, 0, 0);

    // flush coinciding with an issue attempt, a pending push and a possible pop
    repeat (7) tick(1, 0, 0, 0);
    repeat (4) tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(1, 1, 0, 1);
    repeat (6) tick(0, 1, 0, 0);
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);

    // 40 issues against a randomly stalling consumer
    acc_n = 0;
    for (int k = 0; k < 400 && acc_n < 40; k++) begin
      bit rdy;
      rdy = (q.size() < DEPTH);
      if (rdy) acc_n++;
      tick(rdy, 1'($urandom_range(0, 1)), 0, 0);
    end
    chk("rand_issued", 64'(acc_n), 64'd40);
    for (int k = 0; k < 40 && q.size() > 0; k++) tick(0, 1, 0, 0);
    chk("rand_drained", 64'(q.size()), 64'd0);
    tick(0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
